// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus instruction-BRAM write port used by imem_loader.
// The loader connects through the slave modport and the driver/monitor side through master.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic              mem_en_o;
  logic [3:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_din_o;

  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_din_o
  );

  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_din_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and writes it into
// instruction BRAM one 32-bit word at a time, holding the CPU in reset until the image checks out.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      bus,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam logic [32:0] MAX_W = 33'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;

  logic              loading;
  logic              accept;
  logic [31:0]       word;

  assign loading = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept  = bus.rx_valid_i && loading;
  // Bytes shift in from the top, so after four accepts the first byte sits in [7:0].
  assign word    = {bus.rx_data_i, asm_q[31:8]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    idx_d      = idx_q;
    last_d     = last_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          asm_d      = word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            idx_d  = '0;
            last_d = ADDR_W'(word - 32'd1);
            if ({1'b0, word} > MAX_W) state_d = S_ERR;
            else if (word == 32'd0)   state_d = S_CHK;
            else                      state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d      = word;
          csum_d     = csum_q ^ bus.rx_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_en_d   = 1'b1;
            mem_addr_d = idx_q;
            mem_din_d  = word;
            idx_d      = idx_q + 1'b1;
            if (idx_q == last_q) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) state_d = (bus.rx_data_i == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: ;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign bus.rx_ready_o = loading && !reset;
  assign bus.mem_en_o   = mem_en_q;
  assign bus.mem_we_o   = {4{mem_en_q}};
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_din_o  = mem_din_q;
  assign cpu_reset_o    = (state_q != S_DONE);
  assign done_o         = (state_q == S_DONE);
  assign error_o        = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed-vector bench for imem_loader: stimulus pushes expected BRAM writes into a queue,
// a negedge monitor pops and compares every write pulse it sees.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic cpu_reset, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .cpu_reset_o (cpu_reset),
    .done_o      (done),
    .error_o     (error)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write and last one cycle.
  always @(negedge clk) begin
    if (bus.mem_en_o === 1'b1) begin
      wr_t e;
      check("pulse_one_cycle", {31'd0, prev_en}, 32'd0);
      check("mem_we", {28'd0, bus.mem_we_o}, 32'hF);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {22'd0, bus.mem_addr_o}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("mem_addr", {22'd0, bus.mem_addr_o}, {22'd0, e.addr});
        check("mem_din", bus.mem_din_o, e.data);
      end
    end else begin
      check("mem_we_idle", {28'd0, bus.mem_we_o}, 32'h0);
    end
    prev_en = (bus.mem_en_o === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    @(posedge clk);
    repeat (gap) begin
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic send_hdr(input logic [31:0] n, input int gap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input int gap);
    exp_q.push_back('{addr: a, data: w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic idle_and_check(input string name, input logic d, input logic e,
                                input logic c, input logic r);
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    check({name, "_done"},  {31'd0, done},           {31'd0, d});
    check({name, "_error"}, {31'd0, error},          {31'd0, e});
    check({name, "_cpurst"}, {31'd0, cpu_reset},     {31'd0, c});
    check({name, "_ready"}, {31'd0, bus.rx_ready_o}, {31'd0, r});
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ready"},  {31'd0, bus.rx_ready_o}, 32'd1);
    check({name, "_en"},     {31'd0, bus.mem_en_o},   32'd0);
    check({name, "_addr"},   {22'd0, bus.mem_addr_o}, 32'd0);
    check({name, "_din"},    bus.mem_din_o,           32'd0);
    check({name, "_cpurst"}, {31'd0, cpu_reset},      32'd1);
    check({name, "_done"},   {31'd0, done},           32'd0);
    check({name, "_error"},  {31'd0, error},          32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.rx_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'd0, bus.rx_ready_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
  endtask

  task automatic check_drained(input string name);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic good_image(input int gap, input logic [7:0] csum);
    send_hdr(32'd2, gap);
    send_word(10'd0, 32'h0000_0013, gap);
    send_word(10'd1, 32'h0010_0093, gap);
    send_byte(csum, gap);
  endtask

  initial begin
    reset          = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (2) @(posedge clk);
    do_reset();

    // Two-word image with correct checksum, then stray bytes that must be ignored.
    good_image(0, 8'h90);
    idle_and_check("good", 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    idle_and_check("good_after", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("good");

    // Same image with a bad checksum: writes still happen, then sticky error.
    do_reset();
    good_image(0, 8'h91);
    idle_and_check("badsum", 1'b0, 1'b1, 1'b1, 1'b0);
    check_drained("badsum");

    // Length one past the limit: error right after the header, nothing written.
    do_reset();
    send_hdr(32'd1025, 0);
    idle_and_check("toolong", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 0);
    idle_and_check("toolong_after", 1'b0, 1'b1, 1'b1, 1'b0);
    check_drained("toolong");

    // Length exactly at the limit is accepted into the data phase.
    do_reset();
    send_hdr(32'd1024, 0);
    idle_and_check("maxlen", 1'b0, 1'b0, 1'b1, 1'b1);

    // Empty image: checksum of nothing is zero.
    do_reset();
    send_hdr(32'd0, 0);
    send_byte(8'h00, 0);
    idle_and_check("empty", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("empty");

    // Valid toggling every other cycle.
    do_reset();
    good_image(1, 8'h90);
    idle_and_check("gappy", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("gappy");

    // Reset coincides with the last byte of word 1: that write must never appear.
    do_reset();
    send_hdr(32'd2, 0);
    send_word(10'd0, 32'h0000_0013, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    @(negedge clk);
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b1;
    reset          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    check("midrst_ready", {31'd0, bus.rx_ready_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midrst");
    check_drained("midrst");
    good_image(0, 8'h90);
    idle_and_check("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("reload");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 2**ADDR_W, meaning the largest image length accepted, in words.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data_i  in  8  byte from serial receiver.
REQ-006 SHALL have port rx_valid_i  in  1  rx_data_i valid.
REQ-007 SHALL have port rx_ready_o  out  1  loader accepts byte.
REQ-008 SHALL have port mem_en_o  out  1  instruction BRAM write-port enable.
REQ-009 SHALL have port mem_we_o  out  4  BRAM byte write enables.
REQ-010 SHALL have port mem_addr_o  out  ADDR_W  BRAM word address.
REQ-011 SHALL have port mem_din_o  out  32  BRAM write data.
REQ-012 SHALL have port cpu_reset_o  out  1  hold CPU in reset while high.
REQ-013 SHALL have port done_o  out  1  image loaded and checksum good.
REQ-014 SHALL have port error_o  out  1  length or checksum failure, sticky.

Function
REQ-015 SHALL accept a byte only on a cycle with rx_valid_i=1 and rx_ready_o=1 (a handshake).
REQ-016 SHALL implement the states HDR, DATA, CHK, DONE and ERR; rx_ready_o=1 in HDR, DATA and CHK, and 0 in DONE and ERR.
REQ-017 HDR SHALL take 4 bytes as the little-endian 32-bit word count N.
REQ-018 After the 4th header byte: N>MAX_WORDS SHALL go to ERR; N=0 SHALL go to CHK; otherwise SHALL go to DATA.
REQ-019 DATA SHALL assemble every 4 accepted bytes into one little-endian word, with the first byte in bits [7:0].
REQ-020 On the cycle after the 4th byte of a word is accepted, the block SHALL drive mem_en_o=1, mem_we_o=4'hF, mem_addr_o=word index (0-based) and mem_din_o=the assembled word, for exactly one cycle.
REQ-021 The write pulse SHALL NOT stall reception; a byte accepted during the write cycle SHALL begin the next word.
REQ-022 The word index SHALL increment after each write; after the Nth word's 4th byte the state SHALL go to CHK.
REQ-023 A running checksum SHALL be the 8-bit XOR of all DATA bytes; header bytes SHALL be excluded.
REQ-024 CHK SHALL take one byte; if it equals the running checksum the state SHALL go to DONE, otherwise to ERR.
REQ-025 The final word's write pulse SHALL still occur when the checksum byte arrives in the very next cycle.
REQ-026 cpu_reset_o SHALL be 1 in every state except DONE; in DONE it SHALL go to 0 in the same cycle done_o goes to 1.
REQ-027 DONE and ERR SHALL be terminal until reset; rx_valid_i in those states SHALL be ignored.
REQ-028 mem_en_o and mem_we_o SHALL be 0 on every cycle other than write-pulse cycles.
REQ-029 mem_addr_o and mem_din_o SHALL be don't-care when mem_en_o=0 but SHALL be held stable (registered).

Reset
REQ-030 With reset=1 at a clock edge, the block SHALL enter HDR and clear the byte counter, word index, assembled word and checksum.
REQ-031 Reset values SHALL be: rx_ready_o=0 while reset is high, and 1 on the first cycle after release.
REQ-032 Further reset values SHALL be: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_din_o=0, cpu_reset_o=1, done_o=0, error_o=0.
REQ-033 Reset mid-load SHALL abandon the image; any write pulse pending from the cycle of reset SHALL be suppressed.

Verification
REQ-034 Header 02 00 00 00, data 13 00 00 00 93 00 10 00, checksum 0x90 -> writes addr0=0x00000013 and addr1=0x00100093; then done_o=1, cpu_reset_o=0.
REQ-035 Same stream with checksum 0x91 -> both writes occur, then error_o=1, cpu_reset_o=1, rx_ready_o=0.
REQ-036 Header 01 04 00 00 (N=1025, ADDR_W=10) -> no writes; error_o=1 after the 4th byte.
REQ-037 Header 00 00 00 00 followed by checksum 00 -> no writes, done_o=1.
REQ-038 rx_valid_i toggling every other cycle during REQ-034 -> identical writes and result; each write pulse lasts one cycle.
REQ-039 Reset asserted in the same cycle as the 4th data byte -> no write; outputs return to reset values; a reload then succeeds.
